// File: rtl/seq_detect_pkg.sv
// Shared definitions for the serial-pattern detector: run-state encoding and
// the configuration loaded by reset.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Reset-default pattern 0011, length 4; sized at the point of use.
    localparam int unsigned DEF_PAT = 32'd3;
    localparam int unsigned DEF_LEN = 32'd4;

endpackage

// File: rtl/seq_match_core.sv
// Serial history, fill tracking and length-masked pattern compare.
// hit is combinational: it flags that the sample being shifted in this cycle
// completes a match against the low len bits of pat.
module seq_match_core #(
    parameter int MAXLEN = 8,
    parameter int LENW   = $clog2(MAXLEN) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              x,
    input  logic [LENW-1:0]   len,
    input  logic [MAXLEN-1:0] pat,
    input  logic              ovl,
    output logic              hit
);

    logic [MAXLEN-1:0] history_q, history_d;
    logic [LENW-1:0]   fill_q, fill_d;
    logic [MAXLEN-1:0] hist_next_s;
    logic [LENW-1:0]   fill_inc_s;
    logic [MAXLEN-1:0] mask_s;
    logic              hit_s;

    // Post-sample history/fill and the match decision for the current sample.
    always_comb begin
        hist_next_s = (history_q << 1) | {{(MAXLEN-1){1'b0}}, x};
        if (fill_q == LENW'(MAXLEN)) begin
            fill_inc_s = fill_q;
        end else begin
            fill_inc_s = fill_q + LENW'(1);
        end
        for (int i = 0; i < MAXLEN; i++) begin
            mask_s[i] = (i < int'(len));
        end
        hit_s = shift_en && (fill_inc_s >= len) &&
                ((hist_next_s & mask_s) == (pat & mask_s));
    end

    // Next history/fill: clear on run start, shift on qualified samples,
    // and drop the fill after a match when overlap is disabled.
    always_comb begin
        history_d = history_q;
        fill_d    = fill_q;
        if (clr) begin
            history_d = '0;
            fill_d    = '0;
        end else if (shift_en) begin
            history_d = hist_next_s;
            if (hit_s && !ovl) begin
                fill_d = '0;
            end else begin
                fill_d = fill_inc_s;
            end
        end else begin
            history_d = history_q;
            fill_d    = fill_q;
        end
    end

    // History and fill registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            history_q <= '0;
            fill_q    <= '0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
        end
    end

    assign hit = hit_s;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for the programmable serial-pattern detector: config
// registers, IDLE/RUN/DONE sequencing, match counter and config-error pulse.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int MAXLEN = 8,
    parameter int CNTW   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [MAXLEN-1:0]     cfg_pat,
    input  logic [$clog2(MAXLEN):0] cfg_len,
    input  logic                  cfg_ovl,
    input  logic [CNTW-1:0]       cfg_target,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  x,
    input  logic                  x_valid,
    output logic                  match,
    output logic [CNTW-1:0]       match_cnt,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    localparam int LENW = $clog2(MAXLEN) + 1;

    state_t            state_q, state_d;
    logic [MAXLEN-1:0] pat_q, pat_d;
    logic [LENW-1:0]   len_q, len_d;
    logic              ovl_q, ovl_d;
    logic [CNTW-1:0]   tgt_q, tgt_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              match_q, match_d;
    logic              cfg_err_q, cfg_err_d;

    logic cfg_ok_s;
    logic start_ok_s;
    logic shift_en_s;
    logic hit_s;

    // Counter increment that sticks at all-ones.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNTW'(1);
        end
    endfunction

    // Qualifiers: config accepted outside RUN with a legal length; start
    // only outside RUN and only if stop is low; sampling only while running.
    always_comb begin
        cfg_ok_s   = cfg_we && (state_q != ST_RUN) &&
                     (cfg_len != '0) && (cfg_len <= LENW'(MAXLEN));
        start_ok_s = start && !stop && (state_q != ST_RUN);
        shift_en_s = (state_q == ST_RUN) && !stop && x_valid;
    end

    seq_match_core #(
        .MAXLEN (MAXLEN),
        .LENW   (LENW)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_ok_s),
        .shift_en (shift_en_s),
        .x        (x),
        .len      (len_q),
        .pat      (pat_q),
        .ovl      (ovl_q),
        .hit      (hit_s)
    );

    // Next state, counter, match pulse, config load and error pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        match_d   = 1'b0;
        cfg_err_d = cfg_we && !cfg_ok_s;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        tgt_d     = tgt_q;

        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (start_ok_s) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cfg_ok_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (hit_s) begin
                    match_d = 1'b1;
                    cnt_d   = sat_inc(cnt_q);
                    if ((tgt_q != '0) && (cnt_d == tgt_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cfg_ok_s) begin
            pat_d = cfg_pat;
            len_d = cfg_len;
            ovl_d = cfg_ovl;
            tgt_d = cfg_target;
        end else begin
            pat_d = pat_q;
            len_d = len_q;
            ovl_d = ovl_q;
            tgt_d = tgt_q;
        end
    end

    // Controller registers; reset restores the default configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pat_q     <= MAXLEN'(DEF_PAT);
            len_q     <= LENW'(DEF_LEN);
            ovl_q     <= 1'b1;
            tgt_q     <= '0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign cfg_err   = cfg_err_q;

endmodule
